register_bank: RTL and testbench
================================

// Module: register_bank
// PURPOSE
//   32-entry x 32-bit register file with a 3-bit condition-flag register.
//   It sits directly upstream of the ALU: read ports rs/rt drive ALU operands A/B,
//   and the write port takes the ALU result as writeback.
//   Flags (sign/carry/zero) from the ALU are captured for later branch evaluation.
// PARAMETERS
//   DATA_W    32  datapath width (matches ALU A/B/result)
//   ADDR_W    5   register address width; NUM_REGS = 2**ADDR_W
//   ZERO_REG  1   1: register 0 hardwired to 0, writes to it dropped; 0: ordinary register
// PORTS
//   clk       in   1       single clock, all state updates on rising edge
//   rst_n     in   1       asynchronous, active-low reset
//   rs_addr   in   ADDR_W  read port 1 address
//   rt_addr   in   ADDR_W  read port 2 address
//   rs_data   out  DATA_W  read port 1 data (-> ALU A)
//   rt_data   out  DATA_W  read port 2 data (-> ALU B)
//   wr_en     in   1       writeback enable
//   wr_addr   in   ADDR_W  writeback address
//   wr_data   in   DATA_W  writeback data (ALU result)
//   flag_we   in   1       flag capture enable
//   sign_in   in   1       ALU sign
//   carry_in  in   1       ALU carry
//   zero_in   in   1       ALU zero
//   sign_q    out  1       registered sign
//   carry_q   out  1       registered carry
//   zero_q    out  1       registered zero
// BEHAVIOUR
//   - Reset: rst_n=0 clears every register and all three flags to 0 immediately,
//     without waiting for clk. rs_data/rt_data then read 0 and sign_q/carry_q/zero_q are 0.
//     Clock edges while rst_n=0 have no effect.
//   - Reads are combinational (0-cycle latency) from the current array contents.
//   - Write: on a posedge with wr_en=1, reg[wr_addr] <= wr_data.
//     With ZERO_REG=1 and wr_addr=0, the write is dropped.
//   - Bypass: if wr_en=1, wr_addr==rs_addr and the write is not dropped,
//     rs_data = wr_data in the same cycle. rt_data follows the same rule.
//     Both ports may bypass at once.
//   - ZERO_REG=1: address 0 always reads 0, including during bypass.
//   - Flags: on a posedge with flag_we=1, {sign_q,carry_q,zero_q} <= {sign_in,carry_in,zero_in}.
//     When flag_we=0 the flags hold. Flag capture is independent of wr_en, so both may occur on one edge.
//   - Flag-capture latency is 1 cycle; write-to-read latency is 0 cycles through the bypass.
//   - Reset released mid-cycle: the first write takes effect on the first posedge
//     after rst_n goes high.
//   - No X propagation: every output is defined for every address value.
// STRUCTURE
//   - Shared package: DATA_W, ADDR_W and REG_ZERO (=0) constants, plus a
//     flags_t {sign,carry,zero} packed struct shared with the ALU and branch unit.
//   - One sub-module, flag_reg: the 3-bit enable register with async active-low
//     clear, so the branch unit can reuse it.
//   - The array and bypass muxes live in register_bank.
// TESTING
//   1. Reset: load reg5=0x12345678, then pulse rst_n low mid-cycle
//      -> rs_data(addr5)=0 at once and all flags 0.
//   2. Write/read: write reg3=0xC46540AE, then reg4=0x3B9AD31D;
//      read rs=3, rt=4 on the next cycle -> ALU operands 0xC46540AE / 0x3B9AD31D.
//   3. Bypass: wr_en=1, wr_addr=7, wr_data=0x000F4257, rs_addr=rt_addr=7 in the same cycle
//      -> both ports 0x000F4257 before the edge.
//   4. Zero register: write 0xFFFFFFFF to addr 0 with wr_en=1
//      -> rs_data(0)=0 both during that cycle and after it.
//   5. Flags: flag_we=1 with {s,c,z}=101 -> flags 101 after the edge;
//      next cycle flag_we=0 with inputs 010 -> flags hold 101.
//   6. Simultaneous: wr_en=1 and flag_we=1 on the same edge
//      -> both the register and the flags update; a 100-cycle random regression
//      passes against a reference model.

Source files
------------

// File: rtl/register_bank_pkg.sv
// Shared datapath constants and the condition-flag payload used by the
// register bank, the ALU and the branch unit.
package register_bank_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned REG_ZERO = 0;

    typedef struct packed {
        logic sign;
        logic carry;
        logic zero;
    } flags_t;

endpackage

// File: rtl/register_bank_flag_reg.sv
// Three-bit condition-flag register with capture enable and asynchronous
// active-low clear; reusable by the branch unit.
module register_bank_flag_reg
    import register_bank_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  flags_t d,
    output flags_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_bank.sv
// Register file feeding the ALU operand ports, with same-cycle writeback
// bypass and a captured copy of the ALU condition flags.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int unsigned DATA_W   = register_bank_pkg::DATA_W,
    parameter int unsigned ADDR_W   = register_bank_pkg::ADDR_W,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flag_we,
    input  logic              sign_in,
    input  logic              carry_in,
    input  logic              zero_in,
    output logic              sign_q,
    output logic              carry_q,
    output logic              zero_q
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_drop_c;
    logic              wr_live_c;
    flags_t            flags_d;
    flags_t            flags_q;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return ZERO_REG && (addr == ADDR_W'(REG_ZERO));
    endfunction

    assign wr_drop_c = is_zero_reg(wr_addr);
    // Bypass is suppressed while in reset so the ports read the cleared array.
    assign wr_live_c = wr_en && !wr_drop_c && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && !wr_drop_c) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Hardwired zero takes priority over the bypass, which takes priority over the array.
    always_comb begin
        rs_data = regs[rs_addr];
        rt_data = regs[rt_addr];
        if (wr_live_c && (wr_addr == rs_addr)) begin
            rs_data = wr_data;
        end
        if (wr_live_c && (wr_addr == rt_addr)) begin
            rt_data = wr_data;
        end
        if (is_zero_reg(rs_addr)) begin
            rs_data = '0;
        end
        if (is_zero_reg(rt_addr)) begin
            rt_data = '0;
        end
    end

    assign flags_d = '{sign: sign_in, carry: carry_in, zero: zero_in};

    register_bank_flag_reg u_flag_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (flag_we),
        .d     (flags_d),
        .q     (flags_q)
    );

    assign sign_q  = flags_q.sign;
    assign carry_q = flags_q.carry;
    assign zero_q  = flags_q.zero;

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed vectors plus a short
// random run, all checked against a behavioural register-file model.
module tb_register_bank;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        flag_we;
    logic        sign_in;
    logic        carry_in;
    logic        zero_in;
    logic        sign_q;
    logic        carry_q;
    logic        zero_q;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    logic [31:0] mem [32];
    logic [2:0]  mflags;

    register_bank dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .flag_we  (flag_we),
        .sign_in  (sign_in),
        .carry_in (carry_in),
        .zero_in  (zero_in),
        .sign_q   (sign_q),
        .carry_q  (carry_q),
        .zero_q   (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // What a read port must show given the stored contents and the pending write.
    function automatic logic [31:0] exp_read(input logic [4:0] addr);
        if (addr == 5'd0) return 32'h0;
        if (rst_n === 1'b1 && wr_en && wr_addr == addr) return wr_data;
        return mem[addr];
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mflags = 3'b000;
    end

    always @(negedge rst_n) begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mflags = 3'b000;
    end

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            if (wr_en && wr_addr != 5'd0) mem[wr_addr] = wr_data;
            if (flag_we) mflags = {sign_in, carry_in, zero_in};
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_rs", rs_data, exp_read(rs_addr));
            check("model_rt", rt_data, exp_read(rt_addr));
            check("model_flags", {29'h0, sign_q, carry_q, zero_q}, {29'h0, mflags});
        end
    end

    task automatic idle();
        wr_en   = 1'b0;
        wr_addr = 5'd0;
        wr_data = 32'h0;
        flag_we = 1'b0;
        {sign_in, carry_in, zero_in} = 3'b000;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] flags32();
        return {29'h0, sign_q, carry_q, zero_q};
    endfunction

    initial begin
        rst_n   = 1'b0;
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        idle();
        cmp_en = 1'b1;
        next_cycle();
        next_cycle();
        #3;
        check("reset_rs", rs_data, 32'h0);
        check("reset_flags", flags32(), 32'h0);

        // Reset: load reg5 and flags, then assert reset mid-cycle.
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h12345678;
        flag_we = 1'b1; {sign_in, carry_in, zero_in} = 3'b111;
        next_cycle();
        idle();
        rs_addr = 5'd5;
        #2;
        check("pre_reset_rs5", rs_data, 32'h12345678);
        check("pre_reset_flags", flags32(), 32'h7);
        rst_n = 1'b0;
        #1;
        check("async_reset_rs5", rs_data, 32'h0);
        check("async_reset_flags", flags32(), 32'h0);
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'hDEADBEEF; rt_addr = 5'd6;
        flag_we = 1'b1; {sign_in, carry_in, zero_in} = 3'b110;
        #1;
        check("reset_no_bypass", rt_data, 32'h0);
        next_cycle();
        check("reset_edge_ignored", rt_data, 32'h0);
        check("reset_edge_flags", flags32(), 32'h0);
        #1;
        rst_n = 1'b1;
        wr_data = 32'h0BADF00D;
        flag_we = 1'b0;
        next_cycle();
        idle();
        check("first_write_after_reset", rt_data, 32'h0BADF00D);

        // Write then read through the operand ports.
        next_cycle();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hC46540AE;
        next_cycle();
        wr_addr = 5'd4; wr_data = 32'h3B9AD31D;
        next_cycle();
        idle();
        rs_addr = 5'd3; rt_addr = 5'd4;
        #2;
        check("alu_a", rs_data, 32'hC46540AE);
        check("alu_b", rt_data, 32'h3B9AD31D);

        // Same-cycle bypass on both ports.
        next_cycle();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h000F4257;
        rs_addr = 5'd7; rt_addr = 5'd7;
        #2;
        check("bypass_rs", rs_data, 32'h000F4257);
        check("bypass_rt", rt_data, 32'h000F4257);

        // Writes to the zero register are dropped, even on the bypass path.
        next_cycle();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        rs_addr = 5'd0; rt_addr = 5'd7;
        #2;
        check("zero_during_write", rs_data, 32'h0);
        next_cycle();
        idle();
        #2;
        check("zero_after_write", rs_data, 32'h0);
        check("reg7_kept", rt_data, 32'h000F4257);

        // Flag capture and hold.
        next_cycle();
        flag_we = 1'b1; {sign_in, carry_in, zero_in} = 3'b101;
        #2;
        check("flags_before_edge", flags32(), 32'h0);
        next_cycle();
        flag_we = 1'b0; {sign_in, carry_in, zero_in} = 3'b010;
        check("flags_captured", flags32(), 32'h5);
        next_cycle();
        check("flags_held", flags32(), 32'h5);

        // Register write and flag capture on the same edge.
        idle();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55AA55AA;
        flag_we = 1'b1; {sign_in, carry_in, zero_in} = 3'b011;
        next_cycle();
        idle();
        rs_addr = 5'd9;
        #2;
        check("simul_reg", rs_data, 32'h55AA55AA);
        check("simul_flags", flags32(), 32'h3);

        // Random regression against the model.
        for (int n = 0; n < 100; n++) begin
            next_cycle();
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 5'($urandom_range(0, 31));
            wr_data = $urandom;
            flag_we = 1'($urandom_range(0, 1));
            {sign_in, carry_in, zero_in} = 3'($urandom_range(0, 7));
            rs_addr = (n % 4 == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rt_addr = (n % 5 == 0) ? wr_addr : 5'($urandom_range(0, 31));
        end
        next_cycle();
        idle();
        @(negedge clk);
        #1;
        cmp_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
